// File: rtl/atri_multi_trig_generator.sv
// Multi-channel soft-trigger generator: each channel runs an IDLE/ACTIVE(/HOLDOFF) FSM
// producing 2*nblk+2-cycle trigger windows. Define ATRI_MULTI_TRIG_PERIODIC_EN for periodic repeat.
module atri_multi_trig_generator #(
  parameter int NCHAN         = 4,
  parameter int COUNTER_WIDTH = 4,
  parameter int INFO_WIDTH    = 4,
  parameter int PERIOD_WIDTH  = 16,
  parameter int CHAN_BITS     = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [CHAN_BITS-1:0]        cfg_chan_i,
  input  logic [COUNTER_WIDTH-1:0]    cfg_nblk_i,
  input  logic [PERIOD_WIDTH-1:0]     cfg_period_i,
  input  logic                        cfg_wr_i,
  output logic                        cfg_err_o,
  input  logic                        start_i,
  input  logic [NCHAN-1:0]            start_mask_i,
  input  logic                        stop_i,
  input  logic                        clr_info_i,
  input  logic [NCHAN-1:0]            clr_mask_i,
  input  logic                        disable_i,
  output logic [NCHAN-1:0]            trig_o,
  output logic [NCHAN-1:0]            busy_o,
  output logic [NCHAN-1:0]            done_o,
  output logic [NCHAN*INFO_WIDTH-1:0] info_o
);

  // One extra bit so 2*nblk+1 never overflows, even for nblk = all-ones.
  localparam int CNT_W = COUNTER_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  state_t                   state_q [NCHAN];
  logic [COUNTER_WIDTH-1:0] nblk_q  [NCHAN];
  logic [CNT_W-1:0]         cnt_q   [NCHAN];
  logic [INFO_WIDTH-1:0]    info_q  [NCHAN];

  state_t                   state_d  [NCHAN];
  logic [CNT_W-1:0]         cnt_d    [NCHAN];
  logic [INFO_WIDTH-1:0]    info_d   [NCHAN];
  logic [COUNTER_WIDTH-1:0] run_nblk [NCHAN];
  logic [NCHAN-1:0]         done_d;
  logic [NCHAN-1:0]         wr_hit;

`ifdef ATRI_MULTI_TRIG_PERIODIC_EN
  logic [PERIOD_WIDTH-1:0]  period_q [NCHAN];
  logic [PERIOD_WIDTH-1:0]  hold_q   [NCHAN];
  logic [PERIOD_WIDTH-1:0]  hold_d   [NCHAN];
  logic [NCHAN-1:0]         stop_pend_q;
  logic [NCHAN-1:0]         stop_pend_d;
`else
  logic unused_cfg;
  assign unused_cfg = stop_i ^ (^cfg_period_i);
`endif

  logic [31:0] chan_idx;
  logic        chan_ok;
  logic        busy_sel;
  logic        wr_ok;

  // A write is accepted only for an existing, idle channel.
  always_comb begin
    chan_idx = 32'(cfg_chan_i);
    chan_ok  = chan_idx < 32'(NCHAN);
    busy_sel = 1'b0;
    for (int c = 0; c < NCHAN; c++) begin
      if (chan_idx == 32'(c)) busy_sel = busy_o[c];
    end
    wr_ok = cfg_wr_i && chan_ok && !busy_sel;
  end

  always_comb begin
    for (int c = 0; c < NCHAN; c++) begin
      // NOTE: every comb output gets a default before the case, so no path can infer a latch.
      wr_hit[c]   = wr_ok && (chan_idx == 32'(c));
      run_nblk[c] = wr_hit[c] ? cfg_nblk_i : nblk_q[c];
      state_d[c]  = state_q[c];
      cnt_d[c]    = cnt_q[c];
      done_d[c]   = 1'b0;
`ifdef ATRI_MULTI_TRIG_PERIODIC_EN
      hold_d[c]      = hold_q[c];
      stop_pend_d[c] = stop_pend_q[c];
`endif
      case (state_q[c])
        IDLE: begin
          if (start_i && start_mask_i[c] && !disable_i) begin
            state_d[c] = ACTIVE;
            cnt_d[c]   = {run_nblk[c], 1'b1};
`ifdef ATRI_MULTI_TRIG_PERIODIC_EN
            stop_pend_d[c] = 1'b0;
`endif
          end
        end
        ACTIVE: begin
          if (cnt_q[c] != '0) begin
            cnt_d[c]  = cnt_q[c] - CNT_W'(1);
            done_d[c] = (cnt_q[c] == CNT_W'(1));
`ifdef ATRI_MULTI_TRIG_PERIODIC_EN
            if (stop_i && start_mask_i[c]) stop_pend_d[c] = 1'b1;
`endif
          end else begin
            state_d[c] = IDLE;
`ifdef ATRI_MULTI_TRIG_PERIODIC_EN
            if (period_q[c] != '0 && !stop_pend_q[c] && !(stop_i && start_mask_i[c])) begin
              state_d[c] = HOLDOFF;
              hold_d[c]  = period_q[c] - PERIOD_WIDTH'(1);
            end
`endif
          end
        end
`ifdef ATRI_MULTI_TRIG_PERIODIC_EN
        HOLDOFF: begin
          if (stop_i && start_mask_i[c]) begin
            state_d[c] = IDLE;
          end else if (hold_q[c] != '0) begin
            hold_d[c] = hold_q[c] - PERIOD_WIDTH'(1);
          end else if (!disable_i) begin
            state_d[c] = ACTIVE;
            cnt_d[c]   = {nblk_q[c], 1'b1};
          end
        end
`endif
        default: state_d[c] = IDLE;
      endcase
      // Clear beats a same-edge completion.
      if (clr_info_i && clr_mask_i[c]) info_d[c] = '0;
      else if (done_d[c])              info_d[c] = info_q[c] + INFO_WIDTH'(1);
      else                             info_d[c] = info_q[c];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cfg_err_o <= 1'b0;
      trig_o    <= '0;
      busy_o    <= '0;
      done_o    <= '0;
      // NOTE: the per-channel arrays are small registers whose reset values are visible, so each entry is reset.
      for (int c = 0; c < NCHAN; c++) begin
        state_q[c] <= IDLE;
        nblk_q[c]  <= '0;
        cnt_q[c]   <= '0;
        info_q[c]  <= '0;
`ifdef ATRI_MULTI_TRIG_PERIODIC_EN
        period_q[c] <= '0;
        hold_q[c]   <= '0;
`endif
      end
`ifdef ATRI_MULTI_TRIG_PERIODIC_EN
      stop_pend_q <= '0;
`endif
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      cfg_err_o <= cfg_wr_i && !wr_ok;
      done_o    <= done_d;
      for (int c = 0; c < NCHAN; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
        info_q[c]  <= info_d[c];
        trig_o[c]  <= (state_d[c] == ACTIVE);
        busy_o[c]  <= (state_d[c] != IDLE);
        if (wr_hit[c]) nblk_q[c] <= cfg_nblk_i;
`ifdef ATRI_MULTI_TRIG_PERIODIC_EN
        if (wr_hit[c]) period_q[c] <= cfg_period_i;
        hold_q[c] <= hold_d[c];
`endif
      end
`ifdef ATRI_MULTI_TRIG_PERIODIC_EN
      stop_pend_q <= stop_pend_d;
`endif
    end
  end

  always_comb begin
    info_o = '0;
    for (int c = 0; c < NCHAN; c++) begin
      info_o[c*INFO_WIDTH +: INFO_WIDTH] = info_q[c];
    end
  end

endmodule

// File: doc/atri_multi_trig_generator.md
ATRI_MULTI_TRIG_GENERATOR -- requirements
Module: atri_multi_trig_generator

Interface
REQ-001 Parameter NCHAN, default 4: number of independent soft-trigger channels, legal range 1..16.
REQ-002 Parameter COUNTER_WIDTH, default 4: width of each per-channel block-count register.
REQ-003 Parameter INFO_WIDTH, default 4: width of each per-channel completion counter.
REQ-004 Parameter PERIOD_WIDTH, default 16: width of each per-channel holdoff-period register.
REQ-005 Parameter CHAN_BITS, default 2: channel-select width; SHALL equal max(1, clog2(NCHAN)).
REQ-006 Port clk_i, input, 1: the single clock; all logic is rising-edge.
REQ-007 Port rst_n_i, input, 1: reset, synchronous and active-low.
REQ-008 Port cfg_chan_i, input, CHAN_BITS: channel addressed by a config write.
REQ-009 Port cfg_nblk_i, input, COUNTER_WIDTH: new block count.
REQ-010 Port cfg_period_i, input, PERIOD_WIDTH: new holdoff period.
REQ-011 Port cfg_wr_i, input, 1: one-cycle config write strobe.
REQ-012 Port cfg_err_o, output, 1: one-cycle pulse when a write is rejected.
REQ-013 Port start_i, input, 1, and start_mask_i, input, NCHAN: start request and target channels.
REQ-014 Port stop_i, input, 1: ends periodic repetition on the channels in start_mask_i.
REQ-015 Port clr_info_i, input, 1, and clr_mask_i, input, NCHAN: clear completion counters.
REQ-016 Port disable_i, input, 1: blocks new starts.
REQ-017 Port trig_o, output, NCHAN: per-channel soft-trigger level.
REQ-018 Port busy_o, output, NCHAN: channel not IDLE.
REQ-019 Port done_o, output, NCHAN: one-cycle pulse when a trigger window completes.
REQ-020 Port info_o, output, NCHAN*INFO_WIDTH: completion counters; channel c occupies bits [c*INFO_WIDTH +: INFO_WIDTH].

Function
REQ-021 Each channel SHALL run its own FSM with states IDLE, ACTIVE and HOLDOFF; HOLDOFF is used only when the periodic feature is compiled in.
REQ-022 IDLE->ACTIVE on the edge where start_i=1, the channel's start_mask_i bit=1 and disable_i=0; start_i is ignored for channels not in IDLE.
REQ-023 trig_o[c] SHALL rise one cycle after the accepting edge and stay high for exactly 2*nblk+2 cycles; nblk is the value latched at start.
REQ-024 On the last ACTIVE cycle, done_o[c] SHALL pulse and the info counter SHALL increment modulo 2^INFO_WIDTH, wrapping from all-ones to 0.
REQ-025 A write with cfg_chan_i >= NCHAN, or to a channel whose busy_o bit is set, SHALL leave all registers unchanged and pulse cfg_err_o on the following cycle.
REQ-026 An accepted write SHALL load nblk and period for the selected channel and take effect at the next start.
REQ-027 A write and a start on the same edge for the same IDLE channel: the write SHALL be accepted and the start SHALL use the newly written nblk.
REQ-028 If clear and increment hit the same channel on the same edge, the clear SHALL win and the counter SHALL become 0.
REQ-029 disable_i SHALL NOT abort ACTIVE or HOLDOFF windows; it only blocks IDLE->ACTIVE and HOLDOFF->ACTIVE transitions.
REQ-030 The arithmetic for the window count SHALL be COUNTER_WIDTH+1 bits wide, so nblk = all-ones gives a window of 2^(COUNTER_WIDTH+1) cycles with no overflow.

Reset
REQ-031 On an edge with rst_n_i=0, every channel SHALL go to IDLE and nblk, period, info and every output SHALL be 0, including mid-window.
REQ-032 An aborted window SHALL NOT produce a done_o pulse or an info increment.
REQ-033 start_i and cfg_wr_i SHALL be ignored while rst_n_i=0.

Configuration
REQ-034 Macro ATRI_MULTI_TRIG_PERIODIC_EN compiles in periodic mode.
REQ-035 With the macro defined and period != 0: at window end the channel SHALL enter HOLDOFF for exactly period cycles, then re-enter ACTIVE (subject to disable_i); stop_i moves a masked channel in HOLDOFF to IDLE, and a masked channel in ACTIVE goes to IDLE at the end of its window.
REQ-036 Without the macro, or with period = 0: ACTIVE SHALL always go to IDLE, stop_i and cfg_period_i SHALL be ignored, and the period registers SHALL NOT be synthesised.

Verification
REQ-037 Write ch1 nblk=3, then start with mask 0010 -> trig_o[1] is high for 8 cycles starting 1 cycle after start, done_o[1] pulses once, info ch1 = 1, other channels stay 0.
REQ-038 Start ch0 nblk=1, then write ch0 while busy -> cfg_err_o pulses, and the next run still lasts 4 cycles.
REQ-039 Clear and completion on ch2 on the same edge -> info ch2 = 0; 16 completions from 0 with INFO_WIDTH=4 -> wraps to 0.
REQ-040 Pull rst_n_i low mid-window on ch3 -> trig_o[3] = 0 and busy_o[3] = 0 next edge, with no done_o pulse.
REQ-041 With the macro defined, period=5 and nblk=0 -> a 2-cycle high / 5-cycle low pattern repeats; stop_i during HOLDOFF -> IDLE next edge.
REQ-042 Raise disable_i during an ACTIVE window -> the window completes normally, and a start issued while disabled is ignored.
